// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: default width, clog2 helper, state encodings.
package round_robin_arbiter_pkg;

    localparam int NUMBER_WAY_DEFAULT = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/round_robin_arbiter_rotate_priority_picker.sv
// Combinational rotating-priority search: first set request at or above the pointer, wrapping.
module rotate_priority_picker #(
    parameter int NUMBER_WAY  = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic [NUMBER_WAY-1:0]  request_in,
    input  logic [INDEX_WIDTH-1:0] pointer_in,
    output logic [NUMBER_WAY-1:0]  winner_out
);

    localparam logic [2*NUMBER_WAY-1:0] ONE = {{(2*NUMBER_WAY-1){1'b0}}, 1'b1};

    logic [2*NUMBER_WAY-1:0] w_double;
    logic [2*NUMBER_WAY-1:0] w_mask;
    logic [2*NUMBER_WAY-1:0] w_masked;
    logic [2*NUMBER_WAY-1:0] w_lowest;

    // The upper copy supplies the wrapped-around requests below the pointer.
    assign w_double   = {request_in, request_in};
    assign w_mask     = ~((ONE << pointer_in) - ONE);
    assign w_masked   = w_double & w_mask;
    assign w_lowest   = w_masked & (~w_masked + ONE);
    assign winner_out = w_lowest[NUMBER_WAY-1:0] | w_lowest[2*NUMBER_WAY-1:NUMBER_WAY];

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until ack_in.
// Optional ARBITER_LOCK_EN adds lock_in to hold a grant across acknowledgements.
//
// state      | meaning
// ST_IDLE    | no grant outstanding, waiting for any request
// ST_GRANTED | grant_out held until released by an acknowledgement
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int NUMBER_WAY  = NUMBER_WAY_DEFAULT,
    parameter int INDEX_WIDTH = clog2(NUMBER_WAY)
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic [NUMBER_WAY-1:0]  request_in,
    input  logic                   ack_in,
    output logic [NUMBER_WAY-1:0]  grant_out,
    output logic                   grant_valid_out,
    output logic [INDEX_WIDTH-1:0] grant_index_out
`ifdef ARBITER_LOCK_EN
    ,
    input  logic                   lock_in
`endif
);

    arb_state_t             r_state;
    logic [INDEX_WIDTH-1:0] r_pointer;
    logic [NUMBER_WAY-1:0]  r_grant;
    logic                   r_valid;
    logic [INDEX_WIDTH-1:0] r_index;

    logic                   w_release;
    logic [INDEX_WIDTH-1:0] w_pointer_inc;
    logic [INDEX_WIDTH-1:0] w_pick_pointer;
    logic [NUMBER_WAY-1:0]  w_pick_request;
    logic [NUMBER_WAY-1:0]  w_winner;
    logic [INDEX_WIDTH-1:0] w_winner_index;

`ifdef ARBITER_LOCK_EN
    assign w_release = ack_in & ~lock_in;
`else
    assign w_release = ack_in;
`endif

    assign w_pointer_inc = (r_index == INDEX_WIDTH'(NUMBER_WAY - 1)) ? '0
                                                                     : r_index + INDEX_WIDTH'(1);

    // On a release the just-served way is masked so it has a cycle to drop its request.
    assign w_pick_pointer = (r_state == ST_GRANTED) ? w_pointer_inc : r_pointer;
    assign w_pick_request = (r_state == ST_GRANTED) ? (request_in & ~r_grant) : request_in;

    rotate_priority_picker #(
        .NUMBER_WAY  (NUMBER_WAY),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_picker (
        .request_in (w_pick_request),
        .pointer_in (w_pick_pointer),
        .winner_out (w_winner)
    );

    always_comb begin
        w_winner_index = '0;
        for (int i = 0; i < NUMBER_WAY; i++) begin
            if (w_winner[i]) begin
                w_winner_index = INDEX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state   <= ST_IDLE;
            r_pointer <= '0;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_index   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_pick_request) begin
                        r_grant <= w_winner;
                        r_valid <= 1'b1;
                        r_index <= w_winner_index;
                        r_state <= ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    if (w_release) begin
                        r_pointer <= w_pointer_inc;
                        if (|w_pick_request) begin
                            r_grant <= w_winner;
                            r_index <= w_winner_index;
                        end else begin
                            r_grant <= '0;
                            r_valid <= 1'b0;
                            r_index <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant_out       = r_grant;
    assign grant_valid_out = r_valid;
    assign grant_index_out = r_index;

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Round-robin arbiter that turns a vector of per-way requests into a registered one-hot grant. The grant drives the `sel_in` of the downstream `mux_decoded_8`, so the mux forwards the granted way's element. A grant is held until the consumer acknowledges it. Priority then rotates so that every requester is served within NUMBER_WAY grants.

## Interface
- NUMBER_WAY, 8, number of requesters; also the width of the one-hot grant.
- INDEX_WIDTH, $clog2(NUMBER_WAY), width of the encoded grant index.
- clk_in  input  1  clock.
- reset_in  input  1  reset, asynchronous, active-high.
- request_in  input  NUMBER_WAY  per-way request. A requester holds its bit until it is acknowledged.
- ack_in  input  1  consumer has taken the currently granted element this cycle.
- grant_out  output  NUMBER_WAY  registered one-hot grant, connected to the mux `sel_in`. All-zero when no grant.
- grant_valid_out  output  1  grant_out is non-zero.
- grant_index_out  output  INDEX_WIDTH  binary index of the set grant bit. 0 when no grant.
- lock_in  input  1  only present with ARBITER_LOCK_EN. Extends the current grant across acknowledgements.

## Operation
- State machine with two states.
  - IDLE: no grant. If request_in is non-zero, pick a winner, register it in grant_out and go to GRANTED. Otherwise stay in IDLE.
  - GRANTED: grant_out is held stable regardless of request_in changes.
    - ack_in=0: hold.
    - ack_in=1: pointer <= (granted index + 1) mod NUMBER_WAY.
    - ack_in=1 with requests still pending: pick the next winner against the updated pointer and register it the same cycle. The state stays GRANTED, giving back-to-back grants with no bubble.
    - ack_in=1 with no requests pending: grant_out <= 0 and go to IDLE.
- Winner: the first set bit of request_in scanning upward from the pointer, wrapping from bit NUMBER_WAY-1 to bit 0.
- When picking the next winner after an ack, the just-acknowledged way's request is masked for that one cycle. This gives the requester one cycle to drop its request.
- Pointer: INDEX_WIDTH-bit register, reset value 0. It changes only on acknowledgement.
- ack_in while in IDLE is ignored.
- A request that drops while granted is a protocol violation. The grant is still held until ack_in.

## Timing
- Reset values: grant_out=0, grant_valid_out=0, grant_index_out=0, pointer=0, state=IDLE.
- Reset is honoured immediately, including mid-grant. The first grant after reset release uses pointer 0.
- Latency:
  - Request in IDLE to grant visible: 1 cycle.
  - Ack to next grant: 1 cycle, registered in the same edge that retires the current grant.
- grant_out, grant_valid_out and grant_index_out are all registered and change only on the clk_in rising edge.
- grant_out is never multi-hot.
- Starvation bound: a held request is granted within NUMBER_WAY grants.

## Configuration
- ARBITER_LOCK_EN defined:
  - The lock_in port exists.
  - ack_in together with lock_in=1 keeps grant_out unchanged and does not move the pointer, for multi-beat transfers.
  - The first ack_in with lock_in=0 releases the grant normally.
- ARBITER_LOCK_EN undefined:
  - No lock_in port.
  - Every ack_in releases the grant.

## Structure
- Shared package / `parameters.h` holds:
  - the NUMBER_WAY default;
  - the clog2 helper;
  - the state encodings IDLE=1'b0, GRANTED=1'b1.
- One sub-module, `rotate_priority_picker`. It is combinational and implements the rotating priority search:
  - inputs: request vector, pointer;
  - output: one-hot winner, found by doubling the request vector and masking below the pointer.
- The arbiter top holds the state register, pointer, grant registers, one-hot-to-index encoder and lock logic.

## Test plan
All scenarios use NUMBER_WAY=8.
1. Reset pulse.
   - During and after reset: grant_out=8'h00, grant_valid_out=0, grant_index_out=0.
2. request_in=8'h01 after reset.
   - Next cycle: grant_out=8'h01, index 0.
   - Hold ack_in=0 for 5 cycles: grant is unchanged.
3. request_in=8'hFF with ack_in=1 every cycle.
   - Grants 01,02,04,08,10,20,40,80,01 on consecutive cycles, with no bubble.
4. Pointer at 1 (after granting way 0), request_in=8'h81.
   - Grant 8'h80 first. After ack, grant 8'h01.
5. Reset mid-grant.
   - Assert reset_in while grant_out=8'h08: grant_out clears asynchronously.
   - After release with request_in=8'h0C: grant 8'h04 (pointer back at 0).
6. ARBITER_LOCK_EN, request_in=8'h06, way 1 granted.
   - Three acks with lock_in=1: grant stays 8'h02.
   - Next ack with lock_in=0: grant moves to 8'h04.
